// File: rtl/pipe_mult_pkg.sv
// Shared width helpers for the pipelined shift-add multiplier.
// Stage records are built from these so every module agrees on layout.
package pipe_mult_pkg;

    function automatic int chunkWidth(input int widthB, input int stages);
        return widthB / stages;
    endfunction

    function automatic int resultWidth(input int widthA, input int widthB);
        return widthA + widthB;
    endfunction

    // Flat width of the stage record {valid, neg, aMag, bRem, psum}.
    function automatic int stageRecWidth(input int widthA, input int widthB);
        return 2 + widthA + widthB + resultWidth(widthA, widthB);
    endfunction

endpackage

// File: rtl/pipe_mult_stage.sv
// One shift-add stage: adds aMag * (low chunk of bRem) at this stage's weight
// into the running sum and registers the whole record.
module pipe_mult_stage
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 4,
    parameter int STAGES  = 4,
    parameter int IDX     = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_en,
    input  logic [stageRecWidth(WIDTH_A, WIDTH_B)-1:0] i_rec,
    output logic [stageRecWidth(WIDTH_A, WIDTH_B)-1:0] o_rec
);

    localparam int CHUNK = chunkWidth(WIDTH_B, STAGES);
    localparam int RW    = resultWidth(WIDTH_A, WIDTH_B);

    typedef struct packed {
        logic               valid;
        logic               neg;
        logic [WIDTH_A-1:0] aMag;
        logic [WIDTH_B-1:0] bRem;
        logic [RW-1:0]      psum;
    } stageRec_t;

    stageRec_t       w_in;
    stageRec_t       r_rec;
    logic [RW-1:0]   w_prod;
    logic [RW-1:0]   w_sum;

    assign w_in   = i_rec;
    assign w_prod = RW'(w_in.aMag) * RW'(w_in.bRem[CHUNK-1:0]);
    assign w_sum  = w_in.psum + (w_prod << (IDX * CHUNK));

    // Payload only moves with a valid slot, so bubbles leave the last sum untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec <= '0;
        end else if (i_en) begin
            r_rec.valid <= w_in.valid;
            if (w_in.valid) begin
                r_rec.neg  <= w_in.neg;
                r_rec.aMag <= w_in.aMag;
                r_rec.bRem <= w_in.bRem >> CHUNK;
                r_rec.psum <= w_sum;
            end
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/pipe_mult.sv
// Fully pipelined signed/unsigned multiplier with valid/ready on both sides.
// Sign handling wraps a chain of unsigned shift-add stages; stall is global.
module pipe_mult
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 4,
    parameter int STAGES  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_signed,
    input  logic [WIDTH_A-1:0]                      data_a,
    input  logic [WIDTH_B-1:0]                      data_b,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [resultWidth(WIDTH_A, WIDTH_B)-1:0] result
);

    localparam int RW    = resultWidth(WIDTH_A, WIDTH_B);
    localparam int REC_W = stageRecWidth(WIDTH_A, WIDTH_B);

    typedef struct packed {
        logic               valid;
        logic               neg;
        logic [WIDTH_A-1:0] aMag;
        logic [WIDTH_B-1:0] bRem;
        logic [RW-1:0]      psum;
    } stageRec_t;

    stageRec_t        w_front;
    stageRec_t        w_last;
    logic             w_signA;
    logic             w_signB;
    logic             w_stall;
    logic             w_en;
    logic             w_unused;
    logic [REC_W-1:0] w_rec [0:STAGES];

    // Magnitudes keep the most-negative value exact since it fits as unsigned.
    always_comb begin
        w_signA       = in_signed & data_a[WIDTH_A-1];
        w_signB       = in_signed & data_b[WIDTH_B-1];
        w_front       = '0;
        w_front.valid = in_valid & in_ready;
        w_front.neg   = w_signA ^ w_signB;
        w_front.aMag  = w_signA ? -data_a : data_a;
        w_front.bRem  = w_signB ? -data_b : data_b;
    end

    assign w_rec[0] = w_front;

    for (genvar i = 0; i < STAGES; i++) begin : gStage
        pipe_mult_stage #(
            .WIDTH_A (WIDTH_A),
            .WIDTH_B (WIDTH_B),
            .STAGES  (STAGES),
            .IDX     (i)
        ) uStage (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_en),
            .i_rec (w_rec[i]),
            .o_rec (w_rec[i+1])
        );
    end

    assign w_last    = w_rec[STAGES];
    assign w_stall   = w_last.valid & ~out_ready;
    assign w_en      = ~w_stall;
    assign in_ready  = ~w_stall;
    assign out_valid = w_last.valid;
    assign result    = w_last.neg ? -w_last.psum : w_last.psum;

    // The last stage's operand fields have no consumer.
    assign w_unused = ^{w_last.aMag, w_last.bRem};

endmodule

// File: tb/tb_pipe_mult.sv
// Directed bench for pipe_mult: default 4x4/4-stage instance plus an 8x8/2-stage one.
// Expected products are hand-computed constants in the vector tables.
module tb_pipe_mult;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid, inReady, inSigned, outValid, outReady;
    logic [3:0] dataA, dataB;
    logic [7:0] result;

    logic        in8Valid, in8Ready, in8Signed, out8Valid, out8Ready;
    logic [7:0]  data8A, data8B;
    logic [15:0] result8;

    int errors = 0;
    int checks = 0;

    logic [3:0] vecA   [16];
    logic [3:0] vecB   [16];
    logic       vecS   [16];
    logic [7:0] vecExp [16];

    always #5 clk = ~clk;

    pipe_mult dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_signed(inSigned), .data_a(dataA), .data_b(dataB),
        .out_valid(outValid), .out_ready(outReady), .result(result)
    );

    pipe_mult #(.WIDTH_A(8), .WIDTH_B(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in8Valid), .in_ready(in8Ready),
        .in_signed(in8Signed), .data_a(data8A), .data_b(data8B),
        .out_valid(out8Valid), .out_ready(out8Ready), .result(result8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sgn,
                                 input logic [3:0] a, input logic [3:0] b);
        inValid  = valid;
        inSigned = sgn;
        dataA    = a;
        dataB    = b;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Streams vec[0..n-1] with out_ready=1; checks order, latency and no gaps.
    task automatic runStream(input int n, input string tag);
        int count = 0;
        int first = -1;
        int last  = -1;
        outReady = 1'b1;
        for (int c = 0; c < n + 6; c++) begin
            if (c < n) applyStimulus(1'b1, vecS[c], vecA[c], vecB[c]);
            else       applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
            stepCycle();
            if (outValid) begin
                if (count < n) checkOutput($sformatf("%s_res%0d", tag, count), 32'(result), 32'(vecExp[count]));
                if (first < 0) first = c;
                last = c;
                count++;
            end
        end
        checkOutput({tag, "_count"}, count, n);
        checkOutput({tag, "_latency"}, first, 3);
        checkOutput({tag, "_span"}, last - first, n - 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        rst = 1'b1;
        outReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h5);
        in8Valid = 1'b0; in8Signed = 1'b0; data8A = '0; data8B = '0; out8Ready = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        checkOutput("rst_out_valid", 32'(outValid), 0);
        checkOutput("rst_in_ready", 32'(inReady), 1);
        checkOutput("rst_result", 32'(result), 0);
        checkOutput("rst8_out_valid", 32'(out8Valid), 0);

        // Single accept 3 x 5: out_valid rises after the fourth edge.
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h5);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        for (int k = 1; k <= 2; k++) begin
            checkOutput($sformatf("single_early%0d", k), 32'(outValid), 0);
            stepCycle();
        end
        checkOutput("single_early3", 32'(outValid), 0);
        stepCycle();
        checkOutput("single_valid", 32'(outValid), 1);
        checkOutput("single_result", 32'(result), 32'h0F);
        checkOutput("single_in_ready", 32'(inReady), 1);
        stepCycle();
        checkOutput("single_drained", 32'(outValid), 0);
        checkOutput("single_hold", 32'(result), 32'h0F);

        // Back-to-back squares 1..15.
        for (int i = 0; i < 15; i++) begin
            vecA[i] = 4'(i + 1); vecB[i] = 4'(i + 1); vecS[i] = 1'b0;
        end
        vecExp[0] = 8'd1;   vecExp[1] = 8'd4;   vecExp[2] = 8'd9;    vecExp[3] = 8'd16;
        vecExp[4] = 8'd25;  vecExp[5] = 8'd36;  vecExp[6] = 8'd49;   vecExp[7] = 8'd64;
        vecExp[8] = 8'd81;  vecExp[9] = 8'd100; vecExp[10] = 8'd121; vecExp[11] = 8'd144;
        vecExp[12] = 8'd169; vecExp[13] = 8'd196; vecExp[14] = 8'hE1;
        runStream(15, "squares");

        // Signed and unsigned mixed in one stream.
        vecA[0] = 4'hD; vecB[0] = 4'h5; vecS[0] = 1'b1; vecExp[0] = 8'hF1;
        vecA[1] = 4'h8; vecB[1] = 4'h8; vecS[1] = 1'b1; vecExp[1] = 8'h40;
        vecA[2] = 4'h8; vecB[2] = 4'h7; vecS[2] = 1'b1; vecExp[2] = 8'hC8;
        vecA[3] = 4'hF; vecB[3] = 4'hF; vecS[3] = 1'b0; vecExp[3] = 8'hE1;
        vecA[4] = 4'hF; vecB[4] = 4'hF; vecS[4] = 1'b1; vecExp[4] = 8'h01;
        vecA[5] = 4'h8; vecB[5] = 4'h8; vecS[5] = 1'b0; vecExp[5] = 8'h40;
        runStream(6, "mixed");

        // Backpressure: 4 transactions, 3-cycle stall with the head valid.
        vecA[0] = 4'h2; vecB[0] = 4'h3; vecExp[0] = 8'h06;
        vecA[1] = 4'h4; vecB[1] = 4'h5; vecExp[1] = 8'h14;
        vecA[2] = 4'h7; vecB[2] = 4'h9; vecExp[2] = 8'h3F;
        vecA[3] = 4'hF; vecB[3] = 4'h2; vecExp[3] = 8'h1E;
        outReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, vecA[c], vecB[c]);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        outReady = 1'b0;
        #1;
        checkOutput("bp_head_valid", 32'(outValid), 1);
        checkOutput("bp_in_ready", 32'(inReady), 0);
        for (int s = 0; s < 3; s++) begin
            stepCycle();
            checkOutput($sformatf("bp_stall_valid%0d", s), 32'(outValid), 1);
            checkOutput($sformatf("bp_stall_result%0d", s), 32'(result), 32'h06);
            checkOutput($sformatf("bp_stall_in_ready%0d", s), 32'(inReady), 0);
        end
        outReady = 1'b1;
        #1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (outValid) begin
                if (seen < 4) checkOutput($sformatf("bp_res%0d", seen), 32'(result), 32'(vecExp[seen]));
                seen++;
            end
            stepCycle();
        end
        checkOutput("bp_count", seen, 4);

        // Reset with three in flight and a simultaneous offer.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, 4'(c + 3), 4'(c + 3));
            stepCycle();
        end
        applyStimulus(1'b1, 1'b0, 4'h7, 4'h7);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("midrst_out_valid", 32'(outValid), 0);
        checkOutput("midrst_result", 32'(result), 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            stepCycle();
            if (outValid) seen++;
        end
        checkOutput("midrst_stale", seen, 0);
        vecA[0] = 4'h2; vecB[0] = 4'h7; vecS[0] = 1'b0; vecExp[0] = 8'h0E;
        runStream(1, "post_rst");

        // 8x8, two stages: latency 2, full-range corners.
        in8Valid = 1'b1; in8Signed = 1'b0; data8A = 8'hFF; data8B = 8'hFF;
        stepCycle();
        in8Signed = 1'b1; data8A = 8'h80; data8B = 8'h80;
        checkOutput("w8_early", 32'(out8Valid), 0);
        stepCycle();
        in8Valid = 1'b0;
        checkOutput("w8_unsigned_valid", 32'(out8Valid), 1);
        checkOutput("w8_unsigned_result", 32'(result8), 32'hFE01);
        stepCycle();
        checkOutput("w8_signed_valid", 32'(out8Valid), 1);
        checkOutput("w8_signed_result", 32'(result8), 32'h4000);
        stepCycle();
        checkOutput("w8_drained", 32'(out8Valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
